// File: rtl/uart_pkg.sv
// uart_pkg: items shared by the UART TX block and the future RX block.
//   - PARITY_* : values of the PARITY parameter
//   - tx_state_e : TX frame FSM state encoding
//   - clog2 : ceil(log2(v)), used to size counters and pointers
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO.
// Ports:
//   clk, rst_n    clock, async active-low reset (flushes the FIFO)
//   push, wdata   write request; ignored while full
//   pop           read request; ignored while empty
//   rdata         head entry (valid while !empty)
//   full, empty   full is registered; empty decodes the registered level
//   level         occupancy 0..DEPTH
module uart_sync_fifo import uart_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;
  logic [AW:0]      level_nxt;

  // A push while full is dropped even if a pop happens in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (level == '0);
  assign rdata   = mem[rptr];

  always_comb begin
    level_nxt = level;
    case ({do_push, do_pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == (AW+1)'(DEPTH));
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: parametrised UART transmitter with a TX FIFO.
// Frames (start, DATA_BITS LSB first, optional parity, STOP_BITS stops)
// are sent back-to-back while the FIFO holds words.
// Ports:
//   clk, rst_n      clock, async active-low reset (aborts any frame)
//   in_DataByte     word to send, captured when in_Valid & out_Ready
//   in_Valid        write strobe
//   out_Ready       FIFO not full
//   out_DataBit     serial line, idle high
//   out_fBusy       high while any frame bit is driven
//   out_fComplete   pulse on the last cycle of a frame's last stop bit
//   out_fOverflow   pulse after a write attempted while not ready
//   out_Level       FIFO occupancy
module uart_tx_stream import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PARITY_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_BITS-1:0]       in_DataByte,
  input  logic                       in_Valid,
  output logic                       out_Ready,
  output logic                       out_DataBit,
  output logic                       out_fBusy,
  output logic                       out_fComplete,
  output logic                       out_fOverflow,
  output logic [clog2(FIFO_DEPTH):0] out_Level
);

  localparam int CW = clog2(CLKS_PER_BIT);
  localparam int BW = clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PEN   = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  tx_state_e            state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bidx;   // data bit index, reused to count stop bits
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  logic                 fifo_full, fifo_empty, pop, bit_end, stop_end, par_calc;
  logic [DATA_BITS-1:0] fifo_rdata;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_Valid),
    .wdata (in_DataByte),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (out_Level)
  );

  assign out_Ready = ~fifo_full;
  assign bit_end   = (cnt == CNT_LAST);
  assign stop_end  = (state == ST_STOP) && (bidx == STOP_LAST) && bit_end;
  // Pop while idle, or on the final stop cycle so the next start bit follows with no gap.
  assign pop       = ~fifo_empty & ((state == ST_IDLE) | stop_end);
  assign par_calc  = (PARITY == PARITY_ODD) ? ~(^fifo_rdata) : ^fifo_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bidx          <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      out_DataBit   <= 1'b1;
      out_fBusy     <= 1'b0;
      out_fComplete <= 1'b0;
      out_fOverflow <= 1'b0;
    end else begin
      out_fOverflow <= in_Valid & fifo_full;
      // Registered one cycle early so the pulse sits on the final stop cycle.
      out_fComplete <= (state == ST_STOP) && (bidx == STOP_LAST) && (cnt == CNT_PEN);
      // Every state change lands on a bit boundary, so this also clears cnt on entry.
      cnt <= (state == ST_IDLE || bit_end) ? '0 : cnt + 1'b1;

      case (state)
        ST_IDLE: begin
          if (pop) begin
            state       <= ST_START;
            shreg       <= fifo_rdata;
            par_bit     <= par_calc;
            bidx        <= '0;
            out_DataBit <= 1'b0;
            out_fBusy   <= 1'b1;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state       <= ST_DATA;
            bidx        <= '0;
            out_DataBit <= shreg[0];
            shreg       <= shreg >> 1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bidx == DATA_LAST) begin
              bidx <= '0;
              if (PARITY != PARITY_NONE) begin
                state       <= ST_PARITY;
                out_DataBit <= par_bit;
              end else begin
                state       <= ST_STOP;
                out_DataBit <= 1'b1;
              end
            end else begin
              bidx        <= bidx + 1'b1;
              out_DataBit <= shreg[0];
              shreg       <= shreg >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state       <= ST_STOP;
            bidx        <= '0;
            out_DataBit <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (bidx == STOP_LAST) begin
              bidx <= '0;
              if (pop) begin
                state       <= ST_START;
                shreg       <= fifo_rdata;
                par_bit     <= par_calc;
                out_DataBit <= 1'b0;
              end else begin
                state     <= ST_IDLE;
                out_fBusy <= 1'b0;
              end
            end else begin
              bidx <= bidx + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
